// File: rtl/adc_dispatch_arbiter.sv
// Collects one-shot samples from N_CH ADC lanes into per-lane holding registers
// and dispatches them round-robin through a single stall-able output register.
module adc_dispatch_arbiter #(
    parameter int N_CH = 8,
    parameter int DW   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_enable,
    input  logic [N_CH*DW-1:0]       i_data,
    input  logic [N_CH-1:0]          i_rdy,
    input  logic                     i_ready,
    input  logic                     i_ovf_clr,
    output logic [DW-1:0]            o_data,
    output logic [$clog2(N_CH)-1:0]  o_chan,
    output logic                     o_valid,
    output logic [7:0]               o_seq,
    output logic [N_CH-1:0]          o_ovf,
    output logic                     o_busy
);

    localparam int CW = $clog2(N_CH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state, state_nx;
    logic [N_CH-1:0] pend, pend_nx;
    logic [DW-1:0]   hold [N_CH];
    logic [CW-1:0]   ptr;
    logic [CW-1:0]   grant;
    logic [CW-1:0]   scan;
    logic            grant_vld;
    logic            free;
    logic [N_CH-1:0] grant_mask;
    logic [N_CH-1:0] capture;
    logic [N_CH-1:0] take;
    logic [N_CH-1:0] ovf_set;
    logic [7:0]      seq_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_enable) state_nx = RUN;
            RUN:     if (!i_enable) state_nx = DRAIN;
            DRAIN: begin
                if (i_enable)
                    state_nx = RUN;
                else if (pend == '0 && !o_valid)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Round-robin search starting at ptr; index wraps naturally as N_CH is a power of 2.
    always_comb begin
        free       = !o_valid || i_ready;
        grant      = '0;
        grant_vld  = 1'b0;
        scan       = '0;
        grant_mask = '0;
        if (free) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                scan = ptr + CW'(i);
                if (!grant_vld && pend[scan]) begin
                    grant     = scan;
                    grant_vld = 1'b1;
                end
            end
        end
        if (grant_vld)
            grant_mask[grant] = 1'b1;
        capture = (state == RUN) ? i_rdy : '0;
        // A lane granted this cycle frees its holding register, so a new sample there is kept.
        ovf_set = capture & pend & ~grant_mask;
        take    = capture & ~ovf_set;
        pend_nx = (pend & ~grant_mask) | take;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend    <= '0;
            ptr     <= '0;
            o_data  <= '0;
            o_chan  <= '0;
            o_valid <= 1'b0;
            o_seq   <= '0;
            o_ovf   <= '0;
            seq_cnt <= '0;
            for (int unsigned k = 0; k < N_CH; k++)
                hold[k] <= '0;
        end else begin
            pend  <= pend_nx;
            o_ovf <= (i_ovf_clr ? '0 : o_ovf) | ovf_set;
            if (grant_vld) begin
                o_data  <= hold[grant];
                o_chan  <= grant;
                o_valid <= 1'b1;
                o_seq   <= seq_cnt;
                seq_cnt <= seq_cnt + 8'd1;
                ptr     <= grant + CW'(1);
            end else if (free) begin
                o_valid <= 1'b0;
            end
            for (int unsigned k = 0; k < N_CH; k++)
                if (take[k])
                    hold[k] <= i_data[k*DW +: DW];
        end
    end

    assign o_busy = (state != IDLE) || o_valid;

endmodule

// File: tb/tb_adc_dispatch_arbiter.sv
// Bench for adc_dispatch_arbiter: vector table, directed corner sequences and
// random traffic, all checked against a cycle-level reference model.
module tb_adc_dispatch_arbiter;

    localparam int N  = 8;
    localparam int DW = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic [N*DW-1:0]  dat = '0;
    logic [N-1:0]     rdy = '0;
    logic             ready = 1'b0;
    logic             clr = 1'b0;
    logic [DW-1:0]    o_data;
    logic [2:0]       o_chan;
    logic             o_valid;
    logic [7:0]       o_seq;
    logic [N-1:0]     o_ovf;
    logic             o_busy;

    int total = 0;
    int bad   = 0;

    adc_dispatch_arbiter #(.N_CH(N), .DW(DW)) dut (
        .clk(clk), .rst(rst), .i_enable(en), .i_data(dat), .i_rdy(rdy),
        .i_ready(ready), .i_ovf_clr(clr), .o_data(o_data), .o_chan(o_chan),
        .o_valid(o_valid), .o_seq(o_seq), .o_ovf(o_ovf), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    // Reference model: "accepting" follows i_enable one cycle late; "draining" lingers
    // after enable drops until nothing is pending and the output is empty.
    bit            m_acc, m_drn, m_valid;
    bit [N-1:0]    m_pend, m_ovf;
    logic [DW-1:0] m_hold [N];
    logic [DW-1:0] m_data;
    int            m_ptr, m_chan, m_words, m_seq;

    task automatic model_reset();
        m_acc = 0; m_drn = 0; m_valid = 0; m_pend = '0; m_ovf = '0;
        m_ptr = 0; m_chan = 0; m_words = 0; m_seq = 0; m_data = '0;
        for (int k = 0; k < N; k++) m_hold[k] = '0;
    endtask

    task automatic model_step();
        bit free, empty;
        int g;
        bit [N-1:0] setb, takeb;
        free = !m_valid || ready;
        empty = (m_pend == '0) && !m_valid;
        g = -1;
        setb = '0;
        takeb = '0;
        if (free)
            for (int i = 0; i < N; i++)
                if (g < 0 && m_pend[(m_ptr + i) % N]) g = (m_ptr + i) % N;
        for (int k = 0; k < N; k++)
            if (m_acc && rdy[k]) begin
                if (m_pend[k] && k != g) setb[k] = 1'b1;
                else takeb[k] = 1'b1;
            end
        if (g >= 0) begin
            m_data = m_hold[g]; m_chan = g; m_valid = 1;
            m_seq = m_words % 256; m_words++;
            m_pend[g] = 1'b0; m_ptr = (g + 1) % N;
        end else if (free) begin
            m_valid = 0;
        end
        for (int k = 0; k < N; k++)
            if (takeb[k]) begin
                m_hold[k] = dat[k*DW +: DW];
                m_pend[k] = 1'b1;
            end
        m_ovf = (clr ? '0 : m_ovf) | setb;
        m_drn = !en && (m_acc || (m_drn && !empty));
        m_acc = en;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model_valid", 32'(o_valid), 32'(m_valid));
        if (m_valid) begin
            chk("model_data", 32'(o_data), 32'(m_data));
            chk("model_chan", 32'(o_chan), 32'(m_chan));
            chk("model_seq", 32'(o_seq), 32'(m_seq));
        end
        chk("model_ovf", 32'(o_ovf), 32'(m_ovf));
        chk("model_busy", 32'(o_busy), 32'(m_acc || m_drn || m_valid));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #2;
        chk("rst_ctrl", 32'({o_valid, o_busy, o_ovf, o_seq, o_chan}), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_lanes(input logic [DW-1:0] base);
        for (int k = 0; k < N; k++) dat[k*DW +: DW] = base + DW'(k);
    endtask

    typedef struct {
        bit            do_rst;
        bit            en;
        logic [N-1:0]  rdy;
        bit            ready;
        logic [DW-1:0] base;
        bit            exp_valid;
        logic [DW-1:0] exp_data;
        int            exp_chan;
        int            exp_seq;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit e, logic [N-1:0] q, bit rd, logic [DW-1:0] b,
                                bit v, logic [DW-1:0] d, int ch, int sq);
        vec_t t;
        t.do_rst = r; t.en = e; t.rdy = q; t.ready = rd; t.base = b;
        t.exp_valid = v; t.exp_data = d; t.exp_chan = ch; t.exp_seq = sq;
        return t;
    endfunction

    initial begin
        // Single-lane latency: enable first, then a lane-0 strobe appears two edges on.
        vecs.push_back(mk(1, 1, 8'h00, 1, 16'h1234, 0, 16'h0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h01, 1, 16'h1234, 0, 16'h0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 1, 16'h1234, 1, 16'h1234, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 1, 16'h1234, 0, 16'h0, 0, 0));
        // All lanes at once: eight back-to-back words in lane order.
        vecs.push_back(mk(1, 1, 8'h00, 1, 16'h1000, 0, 16'h0, 0, 0));
        vecs.push_back(mk(0, 1, 8'hFF, 1, 16'h1000, 0, 16'h0, 0, 0));
        for (int k = 0; k < N; k++)
            vecs.push_back(mk(0, 1, 8'h00, 1, 16'h1000, 1, 16'h1000 + 16'(k), k, k));
        vecs.push_back(mk(0, 1, 8'h00, 1, 16'h1000, 0, 16'h0, 0, 0));

        do_reset();
        foreach (vecs[i]) begin
            if (vecs[i].do_rst) do_reset();
            en = vecs[i].en; rdy = vecs[i].rdy; ready = vecs[i].ready; clr = 1'b0;
            set_lanes(vecs[i].base);
            tick();
            chk("vec_valid", 32'(o_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                chk("vec_data", 32'(o_data), 32'(vecs[i].exp_data));
                chk("vec_chan", 32'(o_chan), 32'(vecs[i].exp_chan));
                chk("vec_seq", 32'(o_seq), 32'(vecs[i].exp_seq));
            end
            chk("vec_ovf", 32'(o_ovf), 32'd0);
        end

        // Overflow while the output is stalled; second lane-3 sample must be dropped.
        do_reset();
        en = 1; ready = 0; rdy = '0; set_lanes(16'h0); tick();
        rdy = 8'h01; dat[0 +: DW] = 16'h5555; tick();
        rdy = 8'h00; tick();
        chk("ovf_pre_chan", 32'(o_chan), 32'd0);
        rdy = 8'h08; dat[3*DW +: DW] = 16'hAAAA; tick();
        rdy = 8'h08; dat[3*DW +: DW] = 16'hBBBB; tick();
        rdy = 8'h00; tick();
        chk("ovf_flag", 32'(o_ovf), 32'h08);
        chk("ovf_stall_data", 32'(o_data), 32'h5555);
        ready = 1; tick();
        chk("ovf_kept_data", 32'(o_data), 32'hAAAA);
        chk("ovf_kept_seq", 32'(o_seq), 32'd1);
        tick();
        chk("ovf_once", 32'(o_valid), 32'd0);
        clr = 1; tick(); clr = 0;
        chk("ovf_clr", 32'(o_ovf), 32'd0);

        // Pointer at 5 with lanes 2 and 6 pending: lane 6 wins first.
        do_reset();
        en = 1; ready = 0; rdy = '0; set_lanes(16'h2000); tick();
        rdy = 8'h10; tick();
        rdy = 8'h00; tick();
        chk("rr_lane4", 32'(o_chan), 32'd4);
        rdy = 8'h44; tick();
        rdy = 8'h00; ready = 1; tick();
        chk("rr_first", 32'(o_chan), 32'd6);
        tick();
        chk("rr_second", 32'(o_chan), 32'd2);
        tick();
        chk("rr_empty", 32'(o_valid), 32'd0);

        // Drain after enable drops; strobes during drain are ignored.
        do_reset();
        en = 1; ready = 0; rdy = '0; set_lanes(16'h3000); tick();
        rdy = 8'h0E; tick();
        en = 0; rdy = 8'h00; tick();
        chk("drain_w1", 32'({o_valid, o_chan}), 32'({1'b1, 3'd1}));
        rdy = 8'h80; tick();
        rdy = 8'h00; ready = 1; tick();
        chk("drain_w2", 32'(o_data), 32'h3002);
        tick();
        chk("drain_w3", 32'(o_data), 32'h3003);
        tick();
        chk("drain_done", 32'(o_valid), 32'd0);
        for (int c = 0; c < 10 && o_busy; c++) tick();
        chk("drain_idle", 32'(o_busy), 32'd0);
        tick();
        chk("drain_no_l7", 32'(o_valid), 32'd0);

        // Reset with a full output register and four lanes pending.
        do_reset();
        en = 1; ready = 0; rdy = '0; set_lanes(16'h6000); tick();
        rdy = 8'hF1; tick();
        rdy = 8'h00; tick();
        chk("rstmid_pre", 32'(o_valid), 32'd1);
        do_reset();
        ready = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rstmid_quiet", 32'(o_valid), 32'd0);
        end
        rdy = 8'h04; set_lanes(16'h7000); tick();
        rdy = 8'h00; tick();
        chk("rstmid_word", 32'({o_valid, o_chan, o_seq, o_data}), 32'({1'b1, 3'd2, 8'd0, 16'h7002}));

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 799) == 0) do_reset();
            en = ((c / 150) % 4 != 3) ? ($urandom_range(0, 19) != 0) : 1'b0;
            rdy = ($urandom_range(0, 3) == 0) ? N'($urandom) : N'($urandom & $urandom & $urandom);
            dat = {$urandom, $urandom, $urandom, $urandom};
            ready = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 31) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
